mac_link_driver: RTL
====================

// Module: mac_link_driver
// PURPOSE
//  Host-side initiator for the 4-lane byte-serial dot-product MAC pin interface.
//  - Takes a 32b data vector and a 32b weight vector on a valid/ready request.
//  - Serialises both into the MAC byte pins and schedules two read strobes.
//  - Captures the two flag-tagged 9b halves and returns the 18b result on a valid/ready response.
//  - Sits in the test/host FPGA or a wrapper die, directly facing the MAC pins, same clock domain.
// PARAMETERS
//  IO_DLY    0  extra register stages on mac_out before capture; delays every capture edge by IO_DLY
// PORTS
//  clk          in   1   clock, all logic posedge
//  rst_n        in   1   asynchronous active-low reset
//  req_valid    in   1   request valid
//  req_ready    out  1   high only in IDLE
//  req_data     in   32  data vector; byte3 = lane 3
//  req_weights  in   32  weight vector; byte3 = lane 3
//  req_keep_w   in   1   1 = skip the weight load and reuse weights already in the MAC
//  rsp_valid    out  1   result valid; held until rsp_ready
//  rsp_ready    in   1   result accept
//  rsp_result   out  18  {hi9, lo9}
//  rsp_err      out  1   phase error (both captures carried the same flag) or check mismatch
//  mac_byte     out  8   byte pins to MAC (ui_in)
//  mac_sel_w    out  1   1 = MAC shifts weights, 0 = MAC shifts data (uio_in[0])
//  mac_rd       out  1   read strobe (uio_in[1])
//  mac_out      in   10  {flag, half[8:0]} from MAC (uio_out[7:6], uo_out)
// BEHAVIOUR
//  - Pin outputs are registered.
//  - Reset values:
//    - Outputs: mac_byte=0, mac_sel_w=0, mac_rd=0, rsp_valid=0, rsp_result=0, rsp_err=0.
//    - req_ready is 0 while rst_n is low and goes to 1 in IDLE.
//  - MAC facts the schedule relies on:
//    - The MAC shifts one register every edge, weights if sel=1 else data, MSB byte first.
//    - Its result registers one edge after data.
//    - With rd high, the result lands on mac_out one edge later, tagged by a free-running toggle.
//  - States: IDLE -> LD_W(4) -> LD_D1(4) -> PAD(1) -> LD_D2(4) -> DRAIN -> RESP -> IDLE.
//    - req_keep_w=1 skips LD_W.
//  - Load sequence (one beat per cycle):
//    - LD_W:  sel=1; bytes w[31:24], w[23:16], w[15:8], w[7:0].
//    - LD_D*: sel=0; bytes d[31:24] .. d[7:0].
//    - PAD:   sel=0, byte 0x00.
//    - Every other state drives sel=0, byte 0.
//  - Read scheduling:
//    - Let A = the MAC edge that samples the last LD_D1 byte; the second alignment is then A+5.
//    - mac_rd is high for exactly the cycles sampled at edges A+2 and A+7.
//    - The 5-cycle spacing gives opposite toggle parity, so one half of each kind is returned.
//  - Capture:
//    - mac_out is sampled at edges A+3+IO_DLY and A+8+IO_DLY.
//    - flag=1 -> lo9, flag=0 -> hi9.
//    - If both captures carry the same flag: rsp_err=1 and rsp_result = {second, first}.
//  - Response:
//    - RESP asserts rsp_valid.
//    - On rsp_valid & rsp_ready: return to IDLE and clear rsp_valid.
//    - rsp_result and rsp_err stay stable while rsp_valid is high.
//  - Arithmetic:
//    - No arithmetic on the datapath; result is unsigned 18b.
//    - Maximum value 0x3F804 (all bytes 0xFF).
//  - Boundaries:
//    - req_valid is ignored outside IDLE.
//    - Back-to-back requests: the next acceptance is the cycle after the RESP handshake.
//    - Reset mid-operation: immediate IDLE and all outputs to reset values.
//      MAC contents are then undefined, so the next request must not use keep_w.
//    - keep_w on the first request after reset is honoured; the result is undefined (no guard).
// CONFIGURATION
//  MAC_LINK_CHECK_EN defined:
//    - A local 4-lane 8x8 multiply-accumulate of the latched request vectors runs during the load.
//    - A weight copy register is kept so keep_w checks against the last loaded weights.
//    - A mismatch with the captured result sets rsp_err.
//  Not defined: no multipliers, rsp_err reflects phase error only. Ports are identical in both builds.
// STRUCTURE
//  mac_link_pkg:
//    - State enum.
//    - LANES=4, BYTE_W=8, HALF_W=9, RES_W=18.
//    - Read/capture edge offsets (2, 7, 3, 8).
//  One sub-module, mac_link_capture: IO_DLY delay line, flag-steered half registers, phase-error detect.
//  The FSM and byte mux stay in the top.
// TESTING (bench includes a cycle-accurate MAC pin model with a randomly seeded toggle)
//  1. data=0x01020304, w=0x05060708 -> rsp_result=0x00046, rsp_err=0, ~16 cycles.
//  2. All bytes 0xFF -> rsp_result=0x3F804; both toggle seeds give the same answer.
//  3. keep_w=1 after test 1, data=0x0A000000 -> 0x32; LD_W is skipped, mac_sel_w never rises.
//  4. rsp_ready low 20 cycles -> rsp_valid and rsp_result stable; req_ready=0 throughout.
//  5. rst_n low mid-LD_D1 -> all outputs 0 asynchronously; the next full request returns the correct value.
//  6. Model forced to the same flag twice -> rsp_err=1.
//     With MAC_LINK_CHECK_EN, a corrupt half bit also -> rsp_err=1.

Source files
------------

// File: rtl/mac_link_pkg.sv
// Shared constants, state codes and lane helper for the MAC pin-interface driver.
// Optional build feature: MAC_LINK_CHECK_EN (local dot-product cross-check).
`timescale 1ns/1ps
package mac_link_pkg;
    localparam int LANES  = 4;
    localparam int BYTE_W = 8;
    localparam int HALF_W = 9;
    localparam int RES_W  = 18;
    localparam int VEC_W  = LANES * BYTE_W;

    // Offsets in MAC edges after the one that samples the last LD_D1 byte.
    localparam int RD_OFS0  = 2;
    localparam int RD_OFS1  = 7;
    localparam int CAP_OFS0 = 3;
    localparam int CAP_OFS1 = 8;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LD_W  = 3'd1;
    localparam logic [2:0] S_LD_D1 = 3'd2;
    localparam logic [2:0] S_PAD   = 3'd3;
    localparam logic [2:0] S_LD_D2 = 3'd4;
    localparam logic [2:0] S_DRAIN = 3'd5;
    localparam logic [2:0] S_RESP  = 3'd6;

    function automatic logic [BYTE_W-1:0] lane_byte(
        input logic [VEC_W-1:0] v,
        input logic [1:0]       beat
    );
        return v[BYTE_W*(LANES-1-int'(beat)) +: BYTE_W];
    endfunction
endpackage

// File: rtl/mac_link_capture.sv
// Optional IO delay on mac_out, flag-steered half capture and phase-error detect.
// Used by mac_link_driver; no build macros.
`timescale 1ns/1ps
module mac_link_capture
    import mac_link_pkg::*;
#(
    parameter int IO_DLY = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              cap,
    input  logic [HALF_W:0]   mac_out,
    output logic [RES_W-1:0]  result,
    output logic              phase_err
);
    logic [HALF_W:0] pin;

    if (IO_DLY == 0) begin : g_direct
        assign pin = mac_out;
    end else begin : g_dly
        logic [HALF_W:0] sr [IO_DLY];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < IO_DLY; i++) sr[i] <= '0;
            end else begin
                sr[0] <= mac_out;
                for (int i = 1; i < IO_DLY; i++) sr[i] <= sr[i-1];
            end
        end
        assign pin = sr[IO_DLY-1];
    end

    logic              flag;
    logic [HALF_W-1:0] half;
    logic              have;
    logic              first_flag;
    logic [HALF_W-1:0] first_half;

    assign flag = pin[HALF_W];
    assign half = pin[HALF_W-1:0];

    // Second capture decides ordering: flag=1 is the low half.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have       <= 1'b0;
            first_flag <= 1'b0;
            first_half <= '0;
            result     <= '0;
            phase_err  <= 1'b0;
        end else if (clr) begin
            have <= 1'b0;
        end else if (cap) begin
            if (!have) begin
                have       <= 1'b1;
                first_flag <= flag;
                first_half <= half;
            end else begin
                have      <= 1'b0;
                phase_err <= (flag == first_flag);
                if (flag && !first_flag) result <= {first_half, half};
                else                     result <= {half, first_half};
            end
        end
    end
endmodule

// File: rtl/mac_link_driver.sv
// Host-side initiator for the 4-lane byte-serial dot-product MAC pins.
// Define MAC_LINK_CHECK_EN to add a local dot-product cross-check on rsp_err.
`timescale 1ns/1ps
module mac_link_driver
    import mac_link_pkg::*;
#(
    parameter int IO_DLY = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_data,
    input  logic [31:0] req_weights,
    input  logic        req_keep_w,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [17:0] rsp_result,
    output logic        rsp_err,
    output logic [7:0]  mac_byte,
    output logic        mac_sel_w,
    output logic        mac_rd,
    input  logic [9:0]  mac_out
);
    // cnt is the load-phase cycle count; alignment edge A closes cnt = LANES-1.
    localparam logic [7:0] BEAT_LAST = 8'(LANES - 1);
    localparam logic [7:0] D2_FIRST  = 8'(LANES + 1);
    localparam logic [7:0] D2_LAST   = 8'(2 * LANES);
    localparam logic [7:0] RD0  = 8'(RD_OFS0 + LANES - 1);
    localparam logic [7:0] RD1  = 8'(RD_OFS1 + LANES - 1);
    localparam logic [7:0] CAP0 = 8'(CAP_OFS0 + LANES - 1 + IO_DLY);
    localparam logic [7:0] CAP1 = 8'(CAP_OFS1 + LANES - 1 + IO_DLY);

    logic [2:0]       state, state_n;
    logic [7:0]       cnt, cnt_n;
    logic [VEC_W-1:0] d_reg, w_reg, d_src, w_src;
    logic [7:0]       byte_n;
    logic             sel_n, rd_n, accept, cap;
    logic [RES_W-1:0] cap_res;
    logic             phase_err;

    assign accept    = (state == S_IDLE) && req_valid;
    assign req_ready = rst_n && (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign rsp_result = cap_res;
    assign d_src = accept ? req_data : d_reg;
    assign w_src = accept ? req_weights : w_reg;

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 8'd1;
        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (req_valid) state_n = req_keep_w ? S_LD_D1 : S_LD_W;
            end
            S_LD_W: if (cnt == BEAT_LAST) begin
                state_n = S_LD_D1;
                cnt_n   = '0;
            end
            S_LD_D1: if (cnt == BEAT_LAST) state_n = S_PAD;
            S_PAD:   state_n = S_LD_D2;
            S_LD_D2: if (cnt == D2_LAST) state_n = S_DRAIN;
            S_DRAIN: if (cnt == CAP1) state_n = S_RESP;
            S_RESP: begin
                cnt_n = cnt;
                if (rsp_ready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Pins are registered from the next state so they line up with it.
    always_comb begin
        byte_n = '0;
        sel_n  = 1'b0;
        case (state_n)
            S_LD_W: begin
                sel_n  = 1'b1;
                byte_n = lane_byte(w_src, cnt_n[1:0]);
            end
            S_LD_D1: byte_n = lane_byte(d_src, cnt_n[1:0]);
            S_LD_D2: byte_n = lane_byte(d_src, 2'(cnt_n - D2_FIRST));
            default: byte_n = '0;
        endcase
    end

    assign rd_n = (state_n == S_LD_D2 || state_n == S_DRAIN)
               && (cnt_n == RD0 || cnt_n == RD1);
    assign cap  = (state == S_LD_D2 || state == S_DRAIN)
               && (cnt == CAP0 || cnt == CAP1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            d_reg     <= '0;
            w_reg     <= '0;
            mac_byte  <= '0;
            mac_sel_w <= 1'b0;
            mac_rd    <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            mac_byte  <= byte_n;
            mac_sel_w <= sel_n;
            mac_rd    <= rd_n;
            if (accept) begin
                d_reg <= req_data;
                if (!req_keep_w) w_reg <= req_weights;
            end
        end
    end

    mac_link_capture #(.IO_DLY(IO_DLY)) u_capture (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (accept),
        .cap       (cap),
        .mac_out   (mac_out),
        .result    (cap_res),
        .phase_err (phase_err)
    );

`ifdef MAC_LINK_CHECK_EN
    // w_reg keeps the last loaded weights, so keep_w requests check correctly.
    logic [RES_W-1:0]    acc;
    logic [BYTE_W-1:0]   lane_d, lane_w;
    logic [2*BYTE_W-1:0] prod;

    assign lane_d = lane_byte(d_reg, cnt[1:0]);
    assign lane_w = lane_byte(w_reg, cnt[1:0]);
    assign prod   = {8'b0, lane_d} * {8'b0, lane_w};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                acc <= '0;
        else if (accept)           acc <= '0;
        else if (state == S_LD_D1) acc <= acc + {2'b00, prod};
    end

    assign rsp_err = phase_err | (acc != cap_res);
`else
    assign rsp_err = phase_err;
`endif
endmodule
